// File: rtl/instruction_loader.sv
// instruction_loader: collects program bytes from the UART receiver, packs
// them MSB-first into 32-bit instructions and writes them to instruction
// memory at consecutive word addresses, holding the CPU until the HALT
// word has been written or memory is full.
module instruction_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  LOAD_CMD   = 8'h4C,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_write_instruction_flag,
  output logic [31:0]           o_instruction_to_write,
  output logic [31:0]           o_address_to_write_inst,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH-2:0] o_word_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Byte address of the last word slot in memory.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            idx_q;
  logic [31:0]           asm_q;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-2:0] count_q;
  logic                  overflow_q;

  logic start_load;
  logic is_halt;
  logic at_last;
  logic write_ends;
  logic [31:0] asm_shift;

  // A load starts (or restarts) only from IDLE or DONE; in RECV the
  // command byte is ordinary data.
  assign start_load = i_rx_valid && (i_rx_data == LOAD_CMD) &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign is_halt    = (instr_q == HALT_WORD);
  assign at_last    = (addr_q == LAST_ADDR);
  assign write_ends = is_halt || at_last;
  assign asm_shift  = {asm_q[23:0], i_rx_data};

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_load) state_d = ST_RECV;
      ST_RECV:          if (i_rx_valid && (idx_q == 2'd3)) state_d = ST_WRITE;
      ST_WRITE:         state_d = write_ends ? ST_DONE : ST_RECV;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath: byte assembly, address/count bookkeeping and overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q     <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_load) begin
            addr_q     <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_RECV: begin
          if (i_rx_valid) begin
            asm_q <= asm_shift;
            if (idx_q == 2'd3) begin
              // Capture the finished word separately so the write port
              // stays stable while the next word is being assembled.
              instr_q <= asm_shift;
              idx_q   <= 2'd0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          count_q <= count_q + (ADDR_WIDTH-1)'(1);
          if (write_ends) begin
            // A byte arriving now is dropped: the load is over.
            overflow_q <= !is_halt;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(4);
            if (i_rx_valid) begin
              // This byte is byte 0 of the next word.
              asm_q <= asm_shift;
              idx_q <= 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decodes of registered state or register contents.
  assign o_write_instruction_flag = (state_q == ST_WRITE);
  assign o_instruction_to_write   = instr_q;
  assign o_address_to_write_inst  = {{(32-ADDR_WIDTH){1'b0}}, addr_q};
  assign o_cpu_hold               = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_load_done              = (state_q == ST_DONE);
  assign o_overflow               = overflow_q;
  assign o_word_count             = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: two instances (default 4 KiB
// memory and a 16-byte memory) driven by directed and random byte streams.
// A byte-level reference model predicts every memory write and the final
// load status.
module tb_instruction_loader;

  localparam logic [7:0]  CMD  = 8'h4C;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  logic       clk;
  logic       rst      [2];
  logic [7:0] rx_data  [2];
  logic       rx_valid [2];

  logic        wr_a, hold_a, done_a, ovf_a;
  logic [31:0] instr_a, addr_a;
  logic [10:0] cnt_a;
  logic        wr_b, hold_b, done_b, ovf_b;
  logic [31:0] instr_b, addr_b;
  logic [2:0]  cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model state, one slot per instance.
  int          cap        [2] = '{4096, 16};
  bit          m_loading  [2];
  bit          m_done     [2];
  bit          m_ovf      [2];
  bit          m_term_prev[2];
  int          m_addr     [2];
  int          m_count    [2];
  int          m_n        [2];
  logic [31:0] m_word     [2];

  instruction_loader #(.ADDR_WIDTH(12)) dut_a (
    .i_clk(clk), .i_reset(rst[0]), .i_rx_data(rx_data[0]), .i_rx_valid(rx_valid[0]),
    .o_write_instruction_flag(wr_a), .o_instruction_to_write(instr_a),
    .o_address_to_write_inst(addr_a), .o_cpu_hold(hold_a), .o_load_done(done_a),
    .o_overflow(ovf_a), .o_word_count(cnt_a)
  );

  instruction_loader #(.ADDR_WIDTH(4)) dut_b (
    .i_clk(clk), .i_reset(rst[1]), .i_rx_data(rx_data[1]), .i_rx_valid(rx_valid[1]),
    .o_write_instruction_flag(wr_b), .o_instruction_to_write(instr_b),
    .o_address_to_write_inst(addr_b), .o_cpu_hold(hold_b), .o_load_done(done_b),
    .o_overflow(ovf_b), .o_word_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset(input int sel);
    m_loading[sel]   = 1'b0;
    m_done[sel]      = 1'b0;
    m_ovf[sel]       = 1'b0;
    m_term_prev[sel] = 1'b0;
    m_addr[sel]      = 0;
    m_count[sel]     = 0;
    m_n[sel]         = 0;
    m_word[sel]      = '0;
  endtask

  task automatic push_exp(input int sel, input logic [31:0] w, input int a);
    exp_t e;
    e.word = w;
    e.addr = a;
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  // Applies one accepted byte; term reports that it completed the last word.
  task automatic model_byte(input int sel, input logic [7:0] b, output bit term);
    term = 1'b0;
    if (!m_loading[sel]) begin
      if (b == CMD) begin
        m_loading[sel] = 1'b1;
        m_done[sel]    = 1'b0;
        m_ovf[sel]     = 1'b0;
        m_addr[sel]    = 0;
        m_count[sel]   = 0;
        m_n[sel]       = 0;
      end
    end else begin
      m_word[sel] = {m_word[sel][23:0], b};
      m_n[sel]++;
      if (m_n[sel] == 4) begin
        m_n[sel] = 0;
        push_exp(sel, m_word[sel], m_addr[sel]);
        m_count[sel]++;
        if (m_word[sel] == HALT) begin
          m_loading[sel] = 1'b0; m_done[sel] = 1'b1; m_ovf[sel] = 1'b0; term = 1'b1;
        end else if (m_addr[sel] == cap[sel] - 4) begin
          m_loading[sel] = 1'b0; m_done[sel] = 1'b1; m_ovf[sel] = 1'b1; term = 1'b1;
        end else begin
          m_addr[sel] += 4;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock cycle of input on instance sel; a byte in the cycle right
  // after a terminating word is lost by the loader, so the model skips it.
  task automatic drive(input int sel, input bit v, input logic [7:0] b);
    bit term = 1'b0;
    if (v && !m_term_prev[sel]) model_byte(sel, b, term);
    m_term_prev[sel] = term;
    rx_valid[sel] = v;
    rx_data[sel]  = b;
    @(posedge clk);
    #1;
    rx_valid[sel] = 1'b0;
  endtask

  task automatic idle(input int sel, input int n);
    repeat (n) drive(sel, 1'b0, 8'h00);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      drive(sel, 1'b1, w[31-8*i -: 8]);
      idle(sel, $urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset(input int sel);
    rst[sel] = 1'b1;
    drive(sel, 1'b0, 8'h00);
    rst[sel] = 1'b0;
    model_reset(sel);
  endtask

  task automatic check_zero(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_wr"}, {31'b0, wr_a}, 0);     check({tag, "_instr"}, instr_a, 0);
      check({tag, "_addr"}, addr_a, 0);          check({tag, "_hold"}, {31'b0, hold_a}, 0);
      check({tag, "_done"}, {31'b0, done_a}, 0); check({tag, "_ovf"}, {31'b0, ovf_a}, 0);
      check({tag, "_cnt"}, {21'b0, cnt_a}, 0);
    end else begin
      check({tag, "_wr"}, {31'b0, wr_b}, 0);     check({tag, "_instr"}, instr_b, 0);
      check({tag, "_addr"}, addr_b, 0);          check({tag, "_hold"}, {31'b0, hold_b}, 0);
      check({tag, "_done"}, {31'b0, done_b}, 0); check({tag, "_ovf"}, {31'b0, ovf_b}, 0);
      check({tag, "_cnt"}, {29'b0, cnt_b}, 0);
    end
  endtask

  // Status after the bus has been quiet for a few cycles.
  task automatic check_status(input int sel, input string tag);
    @(negedge clk);
    if (sel == 0) begin
      check({tag, "_hold"}, {31'b0, hold_a}, {31'b0, m_loading[0]});
      check({tag, "_done"}, {31'b0, done_a}, {31'b0, m_done[0]});
      check({tag, "_ovf"},  {31'b0, ovf_a},  {31'b0, m_ovf[0]});
      check({tag, "_cnt"},  {21'b0, cnt_a},  m_count[0]);
    end else begin
      check({tag, "_hold"}, {31'b0, hold_b}, {31'b0, m_loading[1]});
      check({tag, "_done"}, {31'b0, done_b}, {31'b0, m_done[1]});
      check({tag, "_ovf"},  {31'b0, ovf_b},  {31'b0, m_ovf[1]});
      check({tag, "_cnt"},  {29'b0, cnt_b},  m_count[1]);
    end
  endtask

  task automatic rand_load(input int sel, input int nwords);
    logic [7:0]  junk;
    logic [31:0] w;
    repeat ($urandom_range(0, 2)) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == CMD) junk = 8'h00;
      drive(sel, 1'b1, junk);
    end
    drive(sel, 1'b1, CMD);
    for (int i = 0; i < nwords; i++) begin
      w = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
      send_word(sel, w, 2);
    end
    send_word(sel, HALT, 1);
    idle(sel, 3);
    check_status(sel, "rand");
  endtask

  // ---------------- scoreboard monitors ----------------
  bit   prev_wr_a = 1'b0;
  bit   prev_wr_b = 1'b0;
  exp_t e_a, e_b;

  // Instance A write port.
  always @(negedge clk) begin
    if (wr_a === 1'b1) begin
      check("a_wr_not_back_to_back", {31'b0, prev_wr_a}, 0);
      if (exp_q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_write: got data %h addr %h expected no write", instr_a, addr_a);
      end else begin
        e_a = exp_q0.pop_front();
        check("a_wr_data", instr_a, e_a.word);
        check("a_wr_addr", addr_a, e_a.addr);
      end
    end
    prev_wr_a = (wr_a === 1'b1);
  end

  // Instance B write port.
  always @(negedge clk) begin
    if (wr_b === 1'b1) begin
      check("b_wr_not_back_to_back", {31'b0, prev_wr_b}, 0);
      if (exp_q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_write: got data %h addr %h expected no write", instr_b, addr_b);
      end else begin
        e_b = exp_q1.pop_front();
        check("b_wr_data", instr_b, e_b.word);
        check("b_wr_addr", addr_b, e_b.addr);
      end
    end
    prev_wr_b = (wr_b === 1'b1);
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rx_valid[s] = 1'b0; rx_data[s] = 8'h00;
      model_reset(s);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");

    // Non-command bytes are ignored; hold rises one cycle after 'L'.
    drive(0, 1'b1, 8'h00);
    drive(0, 1'b1, 8'h13);
    @(negedge clk);
    check("idle_ignores_hold", {31'b0, hold_a}, 0);
    drive(0, 1'b1, CMD);
    @(negedge clk);
    check("cmd_hold_rise", {31'b0, hold_a}, 1);
    idle(0, 2);
    send_word(0, 32'h2001_0005, 0);
    send_word(0, HALT, 0);
    idle(0, 3);
    check_status(0, "basic");
    check("basic_cnt_2", {21'b0, cnt_a}, 2);
    check("basic_done", {31'b0, done_a}, 1);

    // Three words plus HALT with strobes every cycle (bytes land in WRITE).
    drive(0, 1'b1, CMD);
    send_word(0, 32'h1122_3344, 0);
    send_word(0, 32'h5566_7788, 0);
    send_word(0, 32'h99AA_BBCC, 0);
    send_word(0, HALT, 0);
    idle(0, 3);
    check_status(0, "b2b");
    check("b2b_cnt_4", {21'b0, cnt_a}, 4);

    // Restart from DONE: done drops and count restarts.
    drive(0, 1'b1, CMD);
    @(negedge clk);
    check("restart_done_drop", {31'b0, done_a}, 0);
    check("restart_cnt_zero", {21'b0, cnt_a}, 0);
    check("restart_hold", {31'b0, hold_a}, 1);
    send_word(0, 32'hCAFE_0001, 1);
    send_word(0, HALT, 1);
    idle(0, 3);
    check_status(0, "restart");

    // Reset after two bytes of the second word.
    drive(0, 1'b1, CMD);
    send_word(0, 32'h0BAD_F00D, 0);
    idle(0, 2);
    drive(0, 1'b1, 8'hAB);
    drive(0, 1'b1, 8'hCD);
    do_reset(0);
    @(negedge clk);
    check_zero(0, "midreset");
    drive(0, 1'b1, CMD);
    send_word(0, 32'h0000_0013, 0);
    send_word(0, HALT, 0);
    idle(0, 3);
    check_status(0, "after_reset");

    // A command byte right after the HALT write is lost; load stays DONE.
    drive(0, 1'b1, CMD);
    send_word(0, 32'h0102_0304, 0);
    drive(0, 1'b1, 8'hFF); drive(0, 1'b1, 8'hFF);
    drive(0, 1'b1, 8'hFF); drive(0, 1'b1, 8'hFF);
    drive(0, 1'b1, CMD);
    idle(0, 3);
    check_status(0, "drop_after_halt");
    check("drop_after_halt_done", {31'b0, done_a}, 1);

    // Small memory: four non-HALT words fill it, a fifth produces no write.
    drive(1, 1'b1, CMD);
    send_word(1, 32'h0000_0001, 0);
    send_word(1, 32'h0000_0002, 1);
    send_word(1, 32'h0000_0003, 0);
    send_word(1, 32'h0000_0004, 0);
    idle(1, 3);
    check_status(1, "ovf");
    check("ovf_flag", {31'b0, ovf_b}, 1);
    check("ovf_cnt_4", {29'b0, cnt_b}, 4);
    send_word(1, 32'h1234_5678, 0);
    idle(1, 3);
    check("ovf_no_fifth_write", exp_q1.size(), 0);
    check("ovf_still_done", {31'b0, done_b}, 1);

    // Random programs on both instances.
    for (int i = 0; i < 20; i++) rand_load(0, $urandom_range(0, 6));
    for (int i = 0; i < 20; i++) rand_load(1, $urandom_range(0, 6));

    idle(0, 4);
    check("a_pending_writes", exp_q0.size(), 0);
    check("b_pending_writes", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Loader stage directly upstream of instruction fetch. It receives program bytes from the UART receiver, assembles them into 32-bit instructions, and drives the instruction-memory write port: write flag, instruction data and byte address. It holds the CPU in stall/halt while loading and reports completion when the HALT word has been written or memory is full.

## Interface
Parameters:
- ADDR_WIDTH, 12, instruction-memory byte-address width; capacity is 2^ADDR_WIDTH bytes.
- LOAD_CMD, 8'h4C, command byte ('L') that starts a load.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a load.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_write_instruction_flag  out  1  one-cycle memory write enable.
- o_instruction_to_write  out  32  assembled instruction.
- o_address_to_write_inst  out  32  byte address; upper bits are zero, word-aligned.
- o_cpu_hold  out  1  high while loading; drives the fetch stall/halt inputs.
- o_load_done  out  1  high in DONE.
- o_overflow  out  1  memory filled without HALT_WORD; valid in DONE.
- o_word_count  out  ADDR_WIDTH-1  number of words written in the current load.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - A byte equal to LOAD_CMD moves to RECV and clears the address, byte index, o_word_count and o_overflow.
  - All other bytes are ignored.
- RECV: each valid byte shifts into the assembly register MSB first (first byte lands in bits [31:24]). The byte index counts 0–3. The 4th byte moves to WRITE.
- WRITE (exactly one cycle):
  - o_write_instruction_flag=1 with the assembled word and the current address.
  - o_word_count increments.
  - Next state:
    - Word == HALT_WORD: DONE, o_overflow=0.
    - Address == 2^ADDR_WIDTH−4 and word != HALT_WORD: DONE, o_overflow=1.
    - Otherwise: address += 4, then RECV.
  - A byte valid during WRITE is byte 0 of the next word (index becomes 1). It is dropped if the next state is DONE.
- DONE:
  - o_load_done=1.
  - Bytes are ignored except LOAD_CMD, which restarts as from IDLE (memory is overwritten from address 0).
- o_cpu_hold = 1 in RECV and WRITE, 0 in IDLE and DONE.
- Arithmetic:
  - The address register is ADDR_WIDTH bits, increments by 4 and never wraps; the overflow rule stops it.
  - o_address_to_write_inst is the zero-extended address register.
- In RECV, LOAD_CMD bytes are treated as data.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: write flag, instruction, address, hold, done, overflow, word count.
  - Assembly register 0.
- Reset mid-load returns to IDLE the next edge. Words already written remain in memory. The load is not resumed.
- The 4th byte strobe at edge N leads to o_write_instruction_flag high for the cycle after edge N only (registered). Data and address are stable during that cycle.
- In the write cycle, the address shows the word's slot. It is updated to slot+4 on the following edge.
- The o_cpu_hold rise is registered: high the cycle after the LOAD_CMD edge. It falls the cycle after the write of the terminating word.
- o_load_done rises together with the o_cpu_hold fall.
- Outputs hold their last values between writes. The write flag is never high for two consecutive cycles.
- Throughput: back-to-back byte strobes every cycle are supported without loss.

## Test plan
- Reset, then bytes 4C, 20,01,00,05, FF,FF,FF,FF. Required:
  - Write of 32'h2001_0005 at address 0.
  - Write of 32'hFFFF_FFFF at address 4.
  - o_word_count=2, o_load_done=1, o_overflow=0, o_cpu_hold=0 afterwards.
- Bytes 00, 13, 4C in IDLE: only 4C starts the load. o_cpu_hold=1 one cycle after the 4C strobe, and no write occurs before 4 data bytes.
- Byte strobes on consecutive cycles for 3 words plus HALT:
  - Writes at 0, 4, 8, 12.
  - No byte lost; byte arriving in the WRITE cycle lands in [31:24] of the next word.
- ADDR_WIDTH=4 with 4 non-HALT words: writes at 0, 4, 8, 12, then DONE with o_overflow=1 and o_word_count=4. A 5th word produces no write.
- i_reset asserted after 2 data bytes of the 2nd word:
  - Next cycle state IDLE, all outputs 0.
  - A subsequent 4C then 4 bytes writes at address 0.
- In DONE, send 4C and a new program: the load restarts at address 0, o_load_done drops, and o_word_count restarts from 0.
